// File: rtl/acorn128_stream_core.sv
// rtl/acorn128_stream_core.sv - ACORN-128 v3 AEAD engine, W steps per clock, streamed AD/message
module acorn128_stream_core #(
  parameter int W     = 8,
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             decrypt_i,
  input  logic [127:0]     key_i,
  input  logic [127:0]     iv_i,
  input  logic [LEN_W-1:0] ad_len_i,
  input  logic [LEN_W-1:0] msg_len_i,
  input  logic [127:0]     tag_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  input  logic [W-1:0]     din_i,
  output logic             dout_valid_o,
  output logic [W-1:0]     dout_o,
  output logic [127:0]     tag_o,
  output logic             done_o,
  output logic             auth_ok_o,
  output logic             busy_o
);

  localparam int          LOG2W     = $clog2(W);
  localparam logic [10:0] STEP_W    = 11'(W);
  localparam logic [10:0] INIT_LAST = 11'(1792 - W);
  localparam logic [10:0] PAD_LAST  = 11'(256 - W);
  localparam logic [10:0] FIN_LAST  = 11'(768 - W);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_AD, S_AD_PAD, S_MSG, S_MSG_PAD, S_FINAL, S_DONE
  } state_t;

  state_t             r_fsm;
  state_t             w_fsm_next;
  logic               w_step_en;
  logic               w_hs;

  logic [292:0]       r_state;
  logic [127:0]       r_tag;
  logic [127:0]       r_tag_exp;
  logic [127:0]       r_key;
  logic [127:0]       r_iv;
  logic               r_decrypt;
  logic [LEN_W-1:0]   r_ad_words;
  logic [LEN_W-1:0]   r_msg_words;
  logic [LEN_W-1:0]   r_len_cnt;
  logic [10:0]        r_step_cnt;
  logic [W-1:0]       r_dout;
  logic               r_dout_valid;
  logic               r_auth;

  logic [292:0]       w_s;
  logic [127:0]       w_tag_next;
  logic [W-1:0]       w_dout;
  logic [10:0]        w_k;
  logic               w_m;
  logic               w_ca;
  logic               w_cb;
  logic               w_ks;
  logic               w_f;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic ch(input logic a, input logic b, input logic c);
    return (a & b) ^ (~a & c);
  endfunction

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_fsm_next;
  end

  // Next-state logic, step enable and input handshake
  always_comb begin
    w_fsm_next = r_fsm;
    w_step_en  = 1'b0;
    w_hs       = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (start_i) w_fsm_next = S_INIT;
      end
      S_INIT: begin
        w_step_en = 1'b1;
        if (r_step_cnt == INIT_LAST)
          w_fsm_next = (r_ad_words == '0) ? S_AD_PAD : S_AD;
      end
      S_AD: begin
        w_hs      = din_valid_i;
        w_step_en = din_valid_i;
        if (din_valid_i && (r_len_cnt == LEN_W'(1))) w_fsm_next = S_AD_PAD;
      end
      S_AD_PAD: begin
        w_step_en = 1'b1;
        if (r_step_cnt == PAD_LAST)
          w_fsm_next = (r_msg_words == '0) ? S_MSG_PAD : S_MSG;
      end
      S_MSG: begin
        w_hs      = din_valid_i;
        w_step_en = din_valid_i;
        if (din_valid_i && (r_len_cnt == LEN_W'(1))) w_fsm_next = S_MSG_PAD;
      end
      S_MSG_PAD: begin
        w_step_en = 1'b1;
        if (r_step_cnt == PAD_LAST) w_fsm_next = S_FINAL;
      end
      S_FINAL: begin
        w_step_en = 1'b1;
        if (r_step_cnt == FIN_LAST) w_fsm_next = S_DONE;
      end
      S_DONE: begin
        w_fsm_next = S_IDLE;
      end
      default: w_fsm_next = S_IDLE;
    endcase
  end

  // W chained state-update steps; step j uses phase step index r_step_cnt+j
  always_comb begin
    w_s        = r_state;
    w_tag_next = r_tag;
    w_dout     = '0;
    w_k        = '0;
    w_m        = 1'b0;
    w_ca       = 1'b0;
    w_cb       = 1'b0;
    w_ks       = 1'b0;
    w_f        = 1'b0;
    for (int j = 0; j < W; j++) begin
      w_k  = r_step_cnt + 11'(j);
      w_m  = 1'b0;
      w_ca = 1'b1;
      w_cb = 1'b1;
      case (r_fsm)
        S_INIT: begin
          if (w_k == 11'd256)        w_m = r_key[0] ^ 1'b1;
          else if (w_k[10:7] == 4'd1) w_m = r_iv[w_k[6:0]];
          else                        w_m = r_key[w_k[6:0]];
        end
        S_AD: w_m = din_i[j];
        S_AD_PAD: begin
          w_m  = (w_k == 11'd0);
          w_ca = (w_k < 11'd128);
        end
        S_MSG: begin
          w_m  = din_i[j];
          w_cb = 1'b0;
        end
        S_MSG_PAD: begin
          w_m  = (w_k == 11'd0);
          w_ca = (w_k < 11'd128);
          w_cb = 1'b0;
        end
        default: ;
      endcase
      w_s[289] = w_s[289] ^ w_s[235] ^ w_s[230];
      w_s[230] = w_s[230] ^ w_s[196] ^ w_s[193];
      w_s[193] = w_s[193] ^ w_s[160] ^ w_s[154];
      w_s[154] = w_s[154] ^ w_s[111] ^ w_s[107];
      w_s[107] = w_s[107] ^ w_s[66]  ^ w_s[61];
      w_s[61]  = w_s[61]  ^ w_s[23]  ^ w_s[0];
      w_ks = w_s[12] ^ w_s[154] ^ maj(w_s[235], w_s[61], w_s[193])
           ^ ch(w_s[230], w_s[111], w_s[66]);
      if (r_fsm == S_MSG) begin
        w_dout[j] = din_i[j] ^ w_ks;
        // decryption absorbs the recovered plaintext, not the ciphertext
        if (r_decrypt) w_m = w_dout[j];
      end
      w_f = w_s[0] ^ ~w_s[107] ^ maj(w_s[244], w_s[23], w_s[160])
          ^ (w_ca & w_s[196]) ^ (w_cb & w_ks);
      w_s = {w_f ^ w_m, w_s[292:1]};
      // last 128 of 768 finalisation steps; 640 is a multiple of 128
      if ((r_fsm == S_FINAL) && (w_k >= 11'd640)) w_tag_next[w_k[6:0]] = w_ks;
    end
  end

  // Datapath: operand latch, state/tag update, counters, output word and auth flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= '0;
      r_tag        <= '0;
      r_tag_exp    <= '0;
      r_key        <= '0;
      r_iv         <= '0;
      r_decrypt    <= 1'b0;
      r_ad_words   <= '0;
      r_msg_words  <= '0;
      r_len_cnt    <= '0;
      r_step_cnt   <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_auth       <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (r_fsm == S_IDLE) begin
        if (start_i) begin
          r_key       <= key_i;
          r_iv        <= iv_i;
          r_decrypt   <= decrypt_i;
          r_tag_exp   <= tag_i;
          r_ad_words  <= ad_len_i >> LOG2W;
          r_msg_words <= msg_len_i >> LOG2W;
          r_state     <= '0;
          r_tag       <= '0;
          r_auth      <= 1'b0;
          r_step_cnt  <= '0;
        end
      end else begin
        if (w_step_en) begin
          r_state <= w_s;
          r_tag   <= w_tag_next;
        end
        if (w_fsm_next != r_fsm)  r_step_cnt <= '0;
        else if (w_step_en)       r_step_cnt <= r_step_cnt + STEP_W;
        if ((w_fsm_next == S_AD) && (r_fsm != S_AD))         r_len_cnt <= r_ad_words;
        else if ((w_fsm_next == S_MSG) && (r_fsm != S_MSG))  r_len_cnt <= r_msg_words;
        else if (w_hs)                                        r_len_cnt <= r_len_cnt - LEN_W'(1);
        if (w_hs && (r_fsm == S_MSG)) begin
          r_dout       <= w_dout;
          r_dout_valid <= 1'b1;
        end
        if ((r_fsm == S_FINAL) && (w_fsm_next == S_DONE))
          r_auth <= (w_tag_next == r_tag_exp);
      end
    end
  end

  assign din_ready_o  = (r_fsm == S_AD) || (r_fsm == S_MSG);
  assign dout_valid_o = r_dout_valid;
  assign dout_o       = r_dout;
  assign tag_o        = r_tag;
  assign done_o       = (r_fsm == S_DONE);
  assign auth_ok_o    = r_auth;
  assign busy_o       = (r_fsm != S_IDLE) && (r_fsm != S_DONE);

endmodule

// File: tb/tb_acorn128_stream_core.sv
// tb/tb_acorn128_stream_core.sv - randomized self-checking bench against a bit-serial ACORN-128 model
module tb_acorn128_stream_core;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         decrypt_i;
  logic [127:0] key_i;
  logic [127:0] iv_i;
  logic [31:0]  ad_len_i;
  logic [31:0]  msg_len_i;
  logic [127:0] tag_i;
  logic         din_valid_i;
  logic         din_ready_o;
  logic [W-1:0] din_i;
  logic         dout_valid_o;
  logic [W-1:0] dout_o;
  logic [127:0] tag_o;
  logic         done_o;
  logic         auth_ok_o;
  logic         busy_o;

  // free-running clock
  always #5 clk = ~clk;

  acorn128_stream_core #(.W(W), .LEN_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .decrypt_i(decrypt_i),
    .key_i(key_i), .iv_i(iv_i), .ad_len_i(ad_len_i), .msg_len_i(msg_len_i),
    .tag_i(tag_i), .din_valid_i(din_valid_i), .din_ready_o(din_ready_o),
    .din_i(din_i), .dout_valid_o(dout_valid_o), .dout_o(dout_o),
    .tag_o(tag_o), .done_o(done_o), .auth_ok_o(auth_ok_o), .busy_o(busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model: one ACORN step per call ----------------
  bit ms [293];

  function automatic bit maj3(input bit a, input bit b, input bit c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic bit ch3(input bit a, input bit b, input bit c);
    return (a & b) ^ (~a & c);
  endfunction

  task automatic mstep(input bit din, input bit ca, input bit cb, input bit dec, output bit ks);
    bit f, m;
    ms[289] ^= ms[235] ^ ms[230];
    ms[230] ^= ms[196] ^ ms[193];
    ms[193] ^= ms[160] ^ ms[154];
    ms[154] ^= ms[111] ^ ms[107];
    ms[107] ^= ms[66]  ^ ms[61];
    ms[61]  ^= ms[23]  ^ ms[0];
    ks = ms[12] ^ ms[154] ^ maj3(ms[235], ms[61], ms[193]) ^ ch3(ms[230], ms[111], ms[66]);
    m  = dec ? (din ^ ks) : din;
    f  = ms[0] ^ ~ms[107] ^ maj3(ms[244], ms[23], ms[160]) ^ (ca & ms[196]) ^ (cb & ks);
    for (int i = 0; i < 292; i++) ms[i] = ms[i+1];
    ms[292] = f ^ m;
  endtask

  logic [7:0]   q_in[$];
  logic [7:0]   q_exp[$];
  logic [7:0]   q_out[$];
  logic [127:0] m_tag;

  task automatic model_run(input bit dec, input logic [127:0] key, input logic [127:0] iv,
                           input int nad, input int nmsg);
    bit ks, m;
    logic [7:0] w, o;
    for (int i = 0; i < 293; i++) ms[i] = 1'b0;
    q_exp.delete();
    for (int i = 0; i < 1792; i++) begin
      if (i < 128)       m = key[i];
      else if (i < 256)  m = iv[i-128];
      else if (i == 256) m = ~key[0];
      else               m = key[i%128];
      mstep(m, 1'b1, 1'b1, 1'b0, ks);
    end
    for (int n = 0; n < nad; n++) begin
      w = q_in[n];
      for (int b = 0; b < 8; b++) mstep(w[b], 1'b1, 1'b1, 1'b0, ks);
    end
    for (int i = 0; i < 256; i++) mstep(i == 0, i < 128, 1'b1, 1'b0, ks);
    for (int n = 0; n < nmsg; n++) begin
      w = q_in[nad+n];
      for (int b = 0; b < 8; b++) begin
        mstep(w[b], 1'b1, 1'b0, dec, ks);
        o[b] = w[b] ^ ks;
      end
      q_exp.push_back(o);
    end
    for (int i = 0; i < 256; i++) mstep(i == 0, i < 128, 1'b0, 1'b0, ks);
    for (int i = 0; i < 768; i++) begin
      mstep(1'b0, 1'b1, 1'b1, 1'b0, ks);
      if (i >= 640) m_tag[i-640] = ks;
    end
  endtask

  // ---------------- stimulus / observation ----------------
  int cur_nad, cur_nmsg;
  int hs_cnt, dv_cnt, lat_err, busy_cnt, done_cnt;
  logic [127:0] got_tag;
  logic got_auth;
  bit timed_out;

  // call at a negedge; returns at the negedge after the start edge
  task automatic issue_start(input bit dec, input logic [127:0] k, input logic [127:0] v,
                             input int adl, input int ml, input logic [127:0] tg);
    decrypt_i = dec; key_i = k; iv_i = v; ad_len_i = adl; msg_len_i = ml; tag_i = tg;
    cur_nad = adl / 8; cur_nmsg = ml / 8;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // vmode 1 toggles valid, 0 randomises it; pulse_at fires a stray start that many
  // cycles after the last word; abort_at asserts rst once that many words are accepted
  task automatic drive_run(input int vmode, input int pulse_at, input int abort_at);
    int widx = 0, cyc = 0, since_last = 0;
    int ntot = cur_nad + cur_nmsg;
    bit prev_msg = 1'b0, hs;
    hs_cnt = 0; dv_cnt = 0; lat_err = 0; busy_cnt = 0; done_cnt = 0;
    timed_out = 1'b0; q_out.delete();
    while (1) begin
      if (busy_o) busy_cnt++;
      if (dout_valid_o) begin
        dv_cnt++;
        if (!prev_msg) lat_err++;
        q_out.push_back(dout_o);
      end
      if (done_o) begin
        done_cnt++; got_tag = tag_o; got_auth = auth_ok_o;
        break;
      end
      if (cyc > 4000) begin timed_out = 1'b1; break; end
      if (abort_at >= 0 && widx == abort_at) begin rst = 1'b1; break; end
      start_i = 1'b0;
      if (pulse_at >= 0 && widx == ntot && since_last == pulse_at) begin
        start_i = 1'b1; key_i = ~key_i;
      end
      if (widx == ntot) since_last++;
      din_valid_i = (widx < ntot) && ((vmode == 1) ? cyc[0] : ($urandom_range(0, 3) != 0));
      din_i = (widx < ntot) ? q_in[widx] : 8'($urandom);
      hs = din_valid_i && din_ready_o;
      prev_msg = hs && (widx >= cur_nad);
      if (hs) begin widx++; hs_cnt++; end
      @(negedge clk);
      cyc++;
    end
    din_valid_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [7:0] ref_q[$]);
    logic [7:0] g;
    check({name, " words"}, 128'(q_out.size()), 128'(ref_q.size()));
    foreach (ref_q[i]) begin
      g = (i < q_out.size()) ? q_out[i] : 8'hxx;
      check($sformatf("%s[%0d]", name, i), g, ref_q[i]);
    end
  endtask

  logic [7:0]   ad_w[$], pt_w[$], ct_w[$];
  logic [127:0] key2, iv2, t2tag, tg;

  task automatic load_in(input bit use_ct);
    q_in.delete();
    foreach (ad_w[i]) q_in.push_back(ad_w[i]);
    if (use_ct) foreach (ct_w[i]) q_in.push_back(ct_w[i]);
    else        foreach (pt_w[i]) q_in.push_back(pt_w[i]);
  endtask

  // hard stop if something hangs outside the bounded loops
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; decrypt_i = 1'b0; key_i = '0; iv_i = '0;
    ad_len_i = '0; msg_len_i = '0; tag_i = '0; din_valid_i = 1'b0; din_i = '0;
    repeat (3) @(negedge clk);
    check("rst din_ready", din_ready_o, 0);
    check("rst dout_valid", dout_valid_o, 0);
    check("rst dout", dout_o, 0);
    check("rst tag", tag_o, 0);
    check("rst done", done_o, 0);
    check("rst auth", auth_ok_o, 0);
    check("rst busy", busy_o, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", busy_o, 0);

    // test 1: empty AD and message, zero key/IV
    q_in.delete();
    model_run(1'b0, '0, '0, 0, 0);
    issue_start(1'b0, '0, '0, 0, 0, m_tag);
    drive_run(0, -1, -1);
    check("t1 timeout", timed_out, 0);
    check("t1 busy cycles", busy_cnt, 384);
    check("t1 done pulses", done_cnt, 1);
    check("t1 tag", got_tag, m_tag);
    check("t1 auth", got_auth, 1);
    @(negedge clk);
    check("t1 done width", done_o, 0);
    check("t1 auth held", auth_ok_o, 1);

    // test 2: 64-bit AD, 128-bit message, toggling valid
    key2 = {$urandom, $urandom, $urandom, $urandom};
    iv2  = {$urandom, $urandom, $urandom, $urandom};
    ad_w.delete(); pt_w.delete();
    for (int i = 0; i < 8; i++)  ad_w.push_back(8'($urandom));
    for (int i = 0; i < 16; i++) pt_w.push_back(8'($urandom));
    load_in(1'b0);
    model_run(1'b0, key2, iv2, 8, 16);
    ct_w = q_exp;
    t2tag = m_tag;
    issue_start(1'b0, key2, iv2, 64, 128, t2tag);
    drive_run(1, -1, -1);
    check("t2 timeout", timed_out, 0);
    check("t2 handshakes", hs_cnt, 24);
    check("t2 dout pulses", dv_cnt, 16);
    check("t2 latency errs", lat_err, 0);
    check_out("t2 ct", ct_w);
    check("t2 tag", got_tag, t2tag);
    check("t2 auth", got_auth, 1);
    @(negedge clk);

    // test 3: decrypt, good tag then tag bit 5 flipped
    load_in(1'b1);
    issue_start(1'b1, key2, iv2, 64, 128, t2tag);
    drive_run(0, -1, -1);
    check("t3 timeout", timed_out, 0);
    check_out("t3 pt", pt_w);
    check("t3 tag", got_tag, t2tag);
    check("t3 auth", got_auth, 1);
    @(negedge clk);
    issue_start(1'b1, key2, iv2, 64, 128, t2tag ^ (128'd1 << 5));
    drive_run(0, -1, -1);
    check_out("t3b pt", pt_w);
    check("t3b auth", got_auth, 0);
    @(negedge clk);

    // test 4: reset after the third message word, then a clean rerun
    load_in(1'b0);
    issue_start(1'b0, key2, iv2, 64, 128, t2tag);
    drive_run(0, -1, 8 + 3);
    #1;
    check("t4 rst busy", busy_o, 0);
    check("t4 rst ready", din_ready_o, 0);
    check("t4 rst dvalid", dout_valid_o, 0);
    check("t4 rst dout", dout_o, 0);
    check("t4 rst tag", tag_o, 0);
    check("t4 rst done", done_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue_start(1'b0, key2, iv2, 64, 128, t2tag);
    drive_run(0, -1, -1);
    check_out("t4 ct", ct_w);
    check("t4 tag", got_tag, t2tag);
    @(negedge clk);

    // test 6a: stray start during FINAL is ignored
    issue_start(1'b0, key2, iv2, 64, 128, t2tag);
    drive_run(0, 50, -1);
    check("t6 timeout", timed_out, 0);
    check("t6 done pulses", done_cnt, 1);
    check("t6 tag", got_tag, t2tag);
    // test 6b: start held through the done cycle starts one cycle after IDLE
    q_in.delete();
    model_run(1'b0, key2 ^ iv2, iv2, 0, 0);
    decrypt_i = 1'b0; key_i = key2 ^ iv2; iv_i = iv2; ad_len_i = 0; msg_len_i = 0;
    tag_i = m_tag; cur_nad = 0; cur_nmsg = 0;
    start_i = 1'b1;
    @(negedge clk);
    check("t6 idle after done", busy_o, 0);
    @(negedge clk);
    start_i = 1'b0;
    check("t6 restarted", busy_o, 1);
    drive_run(0, -1, -1);
    check("t6 new tag", got_tag, m_tag);
    check("t6 new auth", got_auth, 1);
    @(negedge clk);

    // randomized runs: lengths with truncated low bits, both directions, good/bad tags
    for (int r = 0; r < 6; r++) begin
      int nad, nmsg, adl, ml;
      bit dec, flip;
      nad  = $urandom_range(0, 5);
      nmsg = $urandom_range(0, 6);
      adl  = nad * 8 + $urandom_range(0, 7);
      ml   = nmsg * 8 + $urandom_range(0, 7);
      dec  = 1'($urandom_range(0, 1));
      flip = 1'($urandom_range(0, 1));
      key2 = {$urandom, $urandom, $urandom, $urandom};
      iv2  = {$urandom, $urandom, $urandom, $urandom};
      q_in.delete();
      for (int i = 0; i < nad + nmsg; i++) q_in.push_back(8'($urandom));
      model_run(dec, key2, iv2, nad, nmsg);
      tg = flip ? (m_tag ^ (128'd1 << $urandom_range(0, 127))) : m_tag;
      issue_start(dec, key2, iv2, adl, ml, tg);
      drive_run(0, -1, -1);
      check($sformatf("r%0d timeout", r), timed_out, 0);
      check($sformatf("r%0d handshakes", r), hs_cnt, nad + nmsg);
      check_out($sformatf("r%0d out", r), q_exp);
      check($sformatf("r%0d tag", r), got_tag, m_tag);
      check($sformatf("r%0d auth", r), got_auth, !flip);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
